// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB-first, even parity, two stop bits,
// fed from a small FIFO so queued bytes go out back-to-back.
module uart_tx #(
  parameter int CLK_FREQ     = 1000000,
  parameter int BAUDRATE     = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUDRATE,
  parameter int FIFO_AW      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [15:0]        clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               parity_reg;
  logic [7:0]         head;
  logic               push;
  logic               pop;
  logic               bit_end;
  logic               fifo_empty;

  assign tx_ready   = rst && (fifo_count != FULL);
  assign fifo_empty = (fifo_count == '0);
  assign bit_end    = (clk_cnt == LAST);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];

  // Pops happen only where a new frame can start: from IDLE, or
  // straight out of the last stop bit to keep frames contiguous.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == STOP2 && bit_end));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_reg <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          tx      <= 1'b1;
          if (pop) begin
            shift      <= head;
            parity_reg <= ^head;
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              tx    <= parity_reg;
              state <= PARITY;
            end else begin
              tx      <= shift[1];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP1;
          end
        end
        STOP1: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP2;
          end
        end
        STOP2: begin
          if (bit_end) begin
            tx_done <= 1'b1;
            if (pop) begin
              shift      <= head;
              parity_reg <= ^head;
              tx         <= 1'b0;
              state      <= START;
            end else begin
              tx      <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: stimulus queues expected {parity,byte} words,
// a line decoder pops and compares each frame seen on tx.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];
  bit contig = 1'b0;
  bit first = 1'b1;
  bit rst_hit = 1'b0;

  uart_tx dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (!rst) rst_hit = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Line decoder: samples each bit mid-cell, 104 clocks per bit.
  logic [11:0] smp;
  logic        d_pre;
  logic        d_at;
  int          t_start;
  int          t_prev;
  logic [8:0]  want;

  initial begin
    @(negedge clk);
    forever begin
      while (tx !== 1'b0) @(negedge clk);
      rst_hit = 1'b0;
      t_start = cyc;
      if (contig && !first) chk("frame_gap", t_start - t_prev, 1248);
      first  = 1'b0;
      t_prev = t_start;
      repeat (52) @(negedge clk);
      smp[0] = tx;
      for (int k = 1; k < 12; k++) begin
        repeat (104) @(negedge clk);
        smp[k] = tx;
      end
      repeat (51) @(negedge clk);
      d_pre = tx_done;
      @(negedge clk);
      d_at = tx_done;
      if (!rst_hit) begin
        chk("start_bit", smp[0], 0);
        chk("stop_bits", smp[11:10], 2'b11);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %0h want none", smp[9:1]);
        end else begin
          want = exp_q.pop_front();
          chk("frame_bits", smp[9:1], want);
        end
        chk("done_early", d_pre, 0);
        chk("done_pulse", d_at, 1);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [7:0] b, input logic par);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      total++;
      bad++;
      tx_valid = 1'b0;
      $display("FAIL push_timeout: got ready=0 want ready=1");
    end else begin
      exp_q.push_back({par, b});
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
    chk({nm, "_busy"}, tx_busy, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!tx_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", tx_done, 1);
  endtask

  int d0;

  initial begin
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", tx_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", tx_ready, 1);

    // 1: single byte, latency and busy drop
    push(8'hA5, 1'b0);
    tx_valid = 1'b0;
    chk("t1_count1", fifo_count, 1);
    chk("t1_idle_tx", tx, 1);
    @(negedge clk);
    chk("t1_count0", fifo_count, 0);
    chk("t1_fall", tx, 0);
    chk("t1_busy", tx_busy, 1);
    wait_done();
    chk("t1_busy_drop", tx_busy, 0);
    wait_idle("t1_idle");

    // 2: odd number of ones gives parity 1
    push(8'h07, 1'b1);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("t2_count0", fifo_count, 0);
    wait_idle("t2_idle");

    // 3: held valid, FIFO fills, frames contiguous
    contig = 1'b1;
    first  = 1'b1;
    d0 = done_cnt;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    chk("t3_pop_now", tx, 0);
    chk("t3_count1", fifo_count, 1);
    push(8'h03, 1'b0);
    push(8'h04, 1'b1);
    push(8'h05, 1'b0);
    chk("t3_full", fifo_count, 4);
    chk("t3_ready_low", tx_ready, 0);
    push(8'h06, 1'b0);
    tx_valid = 1'b0;
    wait_idle("t3_idle");
    chk("t3_dones", done_cnt - d0, 6);
    contig = 1'b0;

    // 4: receiver-style decode of edge bytes
    d0 = done_cnt;
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    push(8'h3C, 1'b0);
    push(8'h80, 1'b1);
    tx_valid = 1'b0;
    wait_idle("t4_idle");
    chk("t4_dones", done_cnt - d0, 4);

    // 5: reset during data bit 3 with two bytes queued
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    tx_valid = 1'b0;
    chk("t5_queued", fifo_count, 2);
    repeat (470) @(negedge clk);
    chk("t5_busy_pre", tx_busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_tx", tx, 1);
    chk("t5_busy", tx_busy, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_ready", tx_ready, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rel_ready", tx_ready, 1);
    d0 = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) d0++;
    end
    chk("t5_stay_idle", d0, 0);

    // 6: push on the STOP2-end edge while one byte is queued
    contig = 1'b1;
    first  = 1'b1;
    push(8'hC3, 1'b0);
    push(8'h96, 1'b0);
    tx_valid = 1'b0;
    repeat (1247) @(negedge clk);
    chk("t6_pre_count", fifo_count, 1);
    chk("t6_pre_done", tx_done, 0);
    tx_data  = 8'h7F;
    tx_valid = 1'b1;
    chk("t6_ready", tx_ready, 1);
    exp_q.push_back({1'b1, 8'h7F});
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("t6_count", fifo_count, 1);
    chk("t6_done", tx_done, 1);
    chk("t6_next_start", tx, 0);
    wait_idle("t6_idle");
    contig = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
